// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit arbiter: FSM encoding and default sizing.
package spi_pkg;

   localparam int unsigned NUM_REQ_DEF    = 4;
   localparam int unsigned GAP_CYCLES_DEF = 4;
   localparam int unsigned BUSY_TO_DEF    = 8;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_LAUNCH    = 3'd1;
   localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
   localparam logic [2:0] ST_WAIT_DONE = 3'd3;
   localparam logic [2:0] ST_GAP       = 3'd4;
   localparam logic [2:0] ST_HOLD      = 3'd5;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, with wrap.
module spi_rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [ID_W-1:0]    gnt_o,
   output logic               any_o
);

   always_comb begin
      gnt_o = '0;
      any_o = 1'b0;
      // Outer loop walks priority distance from the pointer; the first hit wins.
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any_o && req_i[i] && ((32'(ptr_i) + k) % NUM_REQ == i)) begin
               any_o = 1'b1;
               gnt_o = ID_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Frame-locked round-robin arbiter feeding a shared byte-wide SPI mode-2 transmit engine.
module spi_tx_arbiter
   import spi_pkg::*;
#(
   parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
   parameter int unsigned ID_W       = 2,
   parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
   parameter int unsigned BUSY_TO    = BUSY_TO_DEF
) (
   input  logic                 In_clk,
   input  logic                 In_rst_n,
   input  logic [NUM_REQ-1:0]   In_req,
   input  logic [NUM_REQ*8-1:0] In_data,
   input  logic [NUM_REQ-1:0]   In_last,
   output logic [NUM_REQ-1:0]   Out_ack,
   output logic                 Out_done,
   output logic [ID_W-1:0]      Out_done_id,
   output logic                 Out_err,
   output logic                 Out_tx_req,
   output logic [7:0]           Out_tx_data,
   input  logic                 In_tx_busy,
   output logic                 Out_owner_vld,
   output logic [ID_W-1:0]      Out_owner
);

   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int unsigned TO_W  = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;

   logic [2:0]         state_q, state_d;
   logic [ID_W-1:0]    rr_q, rr_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [TO_W-1:0]    to_q, to_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic               done_q, done_d;
   logic [ID_W-1:0]    done_id_q, done_id_d;
   logic               err_q, err_d;
   logic               tx_req_q, tx_req_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               owner_vld_q, owner_vld_d;
   logic [ID_W-1:0]    owner_q, owner_d;

   logic [7:0]         data_a [NUM_REQ];
   logic [ID_W-1:0]    pick_gnt;
   logic               pick_any;
   logic [ID_W-1:0]    nxt_owner;

   spi_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req_i (In_req),
      .ptr_i (rr_q),
      .gnt_o (pick_gnt),
      .any_o (pick_any)
   );

   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         data_a[i] = In_data[8*i +: 8];
      end
   end

   assign nxt_owner = (owner_q == ID_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      gap_d       = gap_q;
      to_d        = to_q;
      ack_d       = '0;
      done_d      = 1'b0;
      done_id_d   = done_id_q;
      err_d       = 1'b0;
      tx_req_d    = 1'b0;
      tx_data_d   = tx_data_q;
      owner_vld_d = owner_vld_q;
      owner_d     = owner_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               tx_data_d        = data_a[pick_gnt];
               ack_d[pick_gnt]  = 1'b1;
               owner_d          = pick_gnt;
               owner_vld_d      = ~In_last[pick_gnt];
               state_d          = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            tx_req_d = 1'b1;
            to_d     = '0;
            state_d  = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (In_tx_busy) begin
               state_d = ST_WAIT_DONE;
            end else if (to_q == TO_W'(BUSY_TO-1)) begin
               err_d       = 1'b1;
               owner_vld_d = 1'b0;
               rr_d        = nxt_owner;
               state_d     = ST_IDLE;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (!In_tx_busy) begin
               done_d    = 1'b1;
               done_id_d = owner_q;
               gap_d     = '0;
               state_d   = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_W'(GAP_CYCLES-1)) begin
               if (owner_vld_q) begin
                  state_d = ST_HOLD;
               end else begin
                  rr_d    = nxt_owner;
                  state_d = ST_IDLE;
               end
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         ST_HOLD: begin
            // Locked frame: only the owner can continue, everyone else waits.
            if (In_req[owner_q]) begin
               tx_data_d      = data_a[owner_q];
               ack_d[owner_q] = 1'b1;
               owner_vld_d    = ~In_last[owner_q];
               state_d        = ST_LAUNCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge In_clk) begin
      if (!In_rst_n) begin
         state_q     <= ST_IDLE;
         rr_q        <= '0;
         gap_q       <= '0;
         to_q        <= '0;
         ack_q       <= '0;
         done_q      <= 1'b0;
         done_id_q   <= '0;
         err_q       <= 1'b0;
         tx_req_q    <= 1'b0;
         tx_data_q   <= '0;
         owner_vld_q <= 1'b0;
         owner_q     <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         gap_q       <= gap_d;
         to_q        <= to_d;
         ack_q       <= ack_d;
         done_q      <= done_d;
         done_id_q   <= done_id_d;
         err_q       <= err_d;
         tx_req_q    <= tx_req_d;
         tx_data_q   <= tx_data_d;
         owner_vld_q <= owner_vld_d;
         owner_q     <= owner_d;
      end
   end

   assign Out_ack       = ack_q;
   assign Out_done      = done_q;
   assign Out_done_id   = done_id_q;
   assign Out_err       = err_q;
   assign Out_tx_req    = tx_req_q;
   assign Out_tx_data   = tx_data_q;
   assign Out_owner_vld = owner_vld_q;
   assign Out_owner     = owner_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Scoreboard bench for spi_tx_arbiter with a behavioural busy-only engine model.
module tb_spi_tx_arbiter;

   localparam int unsigned GAP  = 4;
   localparam int unsigned BTO  = 8;
   localparam int unsigned BLEN = 8;
   // tx_req -> engine busy (1) -> busy high (BLEN) -> seen low (1) -> gap -> accept -> launch
   localparam int unsigned EXP_PERIOD = BLEN + GAP + 4;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] d;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_a  [4];
   logic        last_a [4];
   logic [7:0]  rd     [4];
   logic [3:0]  tb_req, tb_last;
   logic [31:0] tb_data;
   logic [3:0]  ack;
   logic        done, err, tx_req, owner_vld;
   logic [1:0]  done_id, owner;
   logic [7:0]  tx_data;

   logic        eng_busy, eng_dead;
   logic [3:0]  eng_cnt;
   logic [7:0]  eng_cap;

   exp_t        sbq [$];
   int unsigned n_vec = 0, n_bad = 0;
   int unsigned cyc = 0, prev_cyc = 0;
   logic        have_prev = 1'b0, chk_period = 1'b0, err_ok = 1'b0, busy_prev = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         tb_req[i]          = req_a[i];
         tb_last[i]         = last_a[i];
         tb_data[8*i +: 8]  = rd[i];
      end
   end

   spi_tx_arbiter #(
      .NUM_REQ    (4),
      .ID_W       (2),
      .GAP_CYCLES (GAP),
      .BUSY_TO    (BTO)
   ) dut (
      .In_clk        (clk),
      .In_rst_n      (rst_n),
      .In_req        (tb_req),
      .In_data       (tb_data),
      .In_last       (tb_last),
      .Out_ack       (ack),
      .Out_done      (done),
      .Out_done_id   (done_id),
      .Out_err       (err),
      .Out_tx_req    (tx_req),
      .Out_tx_data   (tx_data),
      .In_tx_busy    (eng_busy),
      .Out_owner_vld (owner_vld),
      .Out_owner     (owner)
   );

   // Engine model: busy rises the cycle after tx_req and stays high for BLEN cycles.
   always @(posedge clk) begin
      if (!rst_n) begin
         eng_busy <= 1'b0;
         eng_cnt  <= '0;
         eng_cap  <= '0;
      end else if (eng_busy) begin
         if (eng_cnt == 4'(BLEN-1)) eng_busy <= 1'b0;
         else                       eng_cnt  <= eng_cnt + 1'b1;
      end else if (tx_req && !eng_dead) begin
         eng_busy <= 1'b1;
         eng_cnt  <= '0;
         eng_cap  <= tx_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (ack != 4'b0) check("ack_onehot", 32'($onehot(ack)), 1);
         if (err) check("err_allowed", 32'(err_ok), 1);
         if (busy_prev && !eng_busy) check("tx_data_stable", tx_data, eng_cap);
         busy_prev = eng_busy;
         if (tx_req) begin
            if (chk_period && have_prev) check("rr_spacing", cyc - prev_cyc, EXP_PERIOD);
            prev_cyc  = cyc;
            have_prev = 1'b1;
         end
         if (done) begin
            if (sbq.size() == 0) begin
               check("sb_nonempty", 0, 1);
            end else begin
               e = sbq.pop_front();
               check("done_id", done_id, e.id);
               check("done_data", eng_cap, e.d);
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [1:0] id, input logic [7:0] d);
      sbq.push_back('{id: id, d: d});
   endtask

   task automatic send(input logic [1:0] id, input logic [7:0] d, input logic last);
      bit got_ack = 1'b0;
      rd[id]     = d;
      last_a[id] = last;
      req_a[id]  = 1'b1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (ack[id]) begin
            got_ack = 1'b1;
            break;
         end
      end
      check("ack_seen", 32'(got_ack), 1);
      req_a[id] = 1'b0;
      rd[id]    = ~d;
   endtask

   task automatic drain();
      for (int n = 0; n < 600; n++) begin
         if (sbq.size() == 0) break;
         @(negedge clk);
      end
      check("drain", sbq.size(), 0);
      repeat (GAP + 4) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_a[i] = 1'b0; last_a[i] = 1'b0; rd[i] = 8'h00;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      sbq.delete();
   endtask

   initial begin : stim
      int n;
      eng_dead = 1'b0;
      do_reset();
      check("reset_outputs", {ack, done, done_id, err, tx_req, tx_data, owner_vld, owner}, 0);

      // single byte from requester 0
      push(2'd0, 8'hA5);
      send(2'd0, 8'hA5, 1'b1);
      check("txreq_in_ack_cycle", tx_req, 0);
      @(negedge clk);
      check("txreq_after_ack", tx_req, 1);
      check("tx_data_latched", tx_data, 8'hA5);
      @(negedge clk);
      check("txreq_one_cycle", tx_req, 0);
      drain();

      // round robin from a fresh pointer
      do_reset();
      push(2'd0, 8'h10); push(2'd1, 8'h11); push(2'd2, 8'h12); push(2'd3, 8'h13); push(2'd0, 8'h14);
      have_prev  = 1'b0;
      chk_period = 1'b1;
      fork
         begin send(2'd0, 8'h10, 1'b1); send(2'd0, 8'h14, 1'b1); end
         send(2'd1, 8'h11, 1'b1);
         send(2'd2, 8'h12, 1'b1);
         send(2'd3, 8'h13, 1'b1);
      join
      drain();
      chk_period = 1'b0;

      // frame lock: requester 1 three bytes with a pause, requester 2 waiting
      push(2'd1, 8'h11); push(2'd1, 8'h22); push(2'd1, 8'h33); push(2'd2, 8'hC2);
      fork
         begin
            send(2'd1, 8'h11, 1'b0);
            send(2'd1, 8'h22, 1'b0);
            repeat (20) @(negedge clk);
            check("lock_vld", owner_vld, 1);
            check("lock_owner", owner, 1);
            send(2'd1, 8'h33, 1'b1);
         end
         send(2'd2, 8'hC2, 1'b1);
      join
      drain();

      // busy never rises
      eng_dead = 1'b1;
      err_ok   = 1'b1;
      send(2'd3, 8'h5A, 1'b0);
      for (n = 0; n < 10; n++) begin
         @(negedge clk);
         if (tx_req) break;
      end
      check("to_txreq_seen", 32'(tx_req), 1);
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         if (err) break;
      end
      check("to_latency", n + 1, BTO);
      check("to_lock_cleared", owner_vld, 0);
      @(negedge clk);
      check("to_err_pulse", err, 0);
      err_ok   = 1'b0;
      eng_dead = 1'b0;
      push(2'd0, 8'h60); push(2'd3, 8'h63);
      fork
         send(2'd3, 8'h63, 1'b1);
         send(2'd0, 8'h60, 1'b1);
      join
      drain();

      // reset while the engine is busy
      push(2'd1, 8'h71);
      send(2'd1, 8'h71, 1'b1);
      drain();
      send(2'd2, 8'h72, 1'b1);
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (eng_busy) break;
      end
      check("rst_busy_seen", 32'(eng_busy), 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid_outputs", {ack, done, done_id, err, tx_req, tx_data, owner_vld, owner}, 0);
      rst_n = 1'b1;
      push(2'd1, 8'h81); push(2'd3, 8'h83);
      fork
         send(2'd3, 8'h83, 1'b1);
         send(2'd1, 8'h81, 1'b1);
      join
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
